// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and FSM encoding for the sequential divider.
package alu_pkg;
    localparam int DIV_WIDTH = 64;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;
    localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] ALL_ONES   = {DIV_WIDTH{1'b1}};
endpackage

// File: rtl/add_sub_64bit.sv
// add_sub_64bit: combinational adder/subtractor (i_mode=1 computes i_a - i_b).
// Ports: i_a, i_b operands; i_mode 0=add 1=sub; o_result sum/difference;
//        o_carry_flag carry out (for sub: 1 = no borrow); o_overflow_flag signed overflow.
module add_sub_64bit #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_flag,
    output logic             o_overflow_flag
);
    logic [WIDTH-1:0] w_b;
    assign w_b = i_mode ? ~i_b : i_b;
    assign {o_carry_flag, o_result} = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_mode};
    assign o_overflow_flag = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/seq_divider_64bit.sv
// seq_divider_64bit: multi-cycle restoring divider, one quotient bit per cycle.
// Ports: clk, rst (async, active-high); start/is_signed/dividend/divisor request;
//        quotient/remainder results held until next start; busy while working;
//        done one-cycle result pulse; div_by_zero flags a zero divisor.
module seq_divider_64bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    div_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_q, r_rem, w_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_sgn, r_qneg, r_rneg;
    logic [WIDTH:0]   w_shift;
    logic             w_nb, w_unused_ovf, w_a_neg, w_b_neg, w_dz, w_ovf;

    assign w_a_neg = r_sgn & r_a[WIDTH-1];
    assign w_b_neg = r_sgn & r_b[WIDTH-1];
    assign w_dz    = r_b == '0;
    assign w_ovf   = r_sgn && r_a == SIGNED_MIN && r_b == ALL_ONES;
    // Stored remainder is always below the divisor, so WIDTH bits suffice; the
    // extra top bit only exists in the shifted trial value.
    assign w_shift = {r_rem, r_a[WIDTH-1]};

    add_sub_64bit #(.WIDTH(WIDTH)) u_sub (
        .i_a             (w_shift[WIDTH-1:0]),
        .i_b             (r_b),
        .i_mode          (1'b1),
        .o_result        (w_diff),
        .o_carry_flag    (w_nb),
        .o_overflow_flag (w_unused_ovf)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:    w_next = start ? PREP : IDLE;
            PREP: begin
                busy   = 1'b1;
                w_next = (w_dz || w_ovf) ? DONE : CALC;
            end
            CALC: begin
                busy   = 1'b1;
                w_next = (r_cnt == CW'(WIDTH-1)) ? FIX : CALC;
            end
            FIX: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_sgn       <= 1'b0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a         <= dividend;
                    r_b         <= divisor;
                    r_sgn       <= is_signed;
                    div_by_zero <= 1'b0;
                end
                PREP: if (w_dz) begin
                    quotient    <= ALL_ONES;
                    remainder   <= r_a;
                    div_by_zero <= 1'b1;
                end else if (w_ovf) begin
                    quotient  <= r_a;
                    remainder <= '0;
                end else begin
                    r_a    <= w_a_neg ? -r_a : r_a;
                    r_b    <= w_b_neg ? -r_b : r_b;
                    r_qneg <= w_a_neg ^ w_b_neg;
                    r_rneg <= w_a_neg;
                    r_rem  <= '0;
                    r_cnt  <= '0;
                end
                CALC: begin
                    r_a   <= r_a << 1;
                    r_cnt <= r_cnt + 1'b1;
                    // A set bit WIDTH means the trial value exceeds any divisor.
                    if (w_shift[WIDTH] | w_nb) begin
                        r_rem <= w_diff;
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    quotient  <= r_qneg ? -r_q : r_q;
                    remainder <= r_rneg ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end
endmodule
